// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline run controller.
// Holds the controller state encoding, the fault codes and the halt opcode.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        STEP  = 3'd4,
        DRAIN = 3'd5,
        HALT  = 3'd6,
        FAULT = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_DEADLOCK = 2'd1,
        FAULT_PC       = 2'd2,
        FAULT_BUDGET   = 2'd3
    } fault_e;

    // syscall marks the end of the program
    localparam logic [31:0] HALT_INSTR = 32'h0000000C;

endpackage

// File: rtl/pipeline_run_ctrl_stall_watchdog.sv
// Consecutive full-stall counter for the run controller.
// Flags deadlock on the stall cycle that would push the count past MAX_STALL.
module stall_watchdog #(
    parameter int unsigned MAX_STALL = 10
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic StallF,
    input  logic StallD,
    output logic deadlock
);

    localparam int CNT_W = $clog2(MAX_STALL + 2);

    logic [CNT_W-1:0] stallCnt;
    logic             fullStall;

    assign fullStall = enable && StallF && StallD;
    assign deadlock  = fullStall && (stallCnt == CNT_W'(MAX_STALL));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (clear || !fullStall) begin
            stallCnt <= '0;
        end else if (!deadlock) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller sequencing the 5-stage MIPS datapath: reset priming,
// run/pause/step, halt drain and fault capture with frozen outputs.
module pipeline_run_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYC    = 2,
    parameter int unsigned DRAIN_CYC    = 3,
    parameter int unsigned MAX_STALL    = 10,
    parameter logic [31:0] PC_LIMIT     = 32'h00000070,
    parameter int unsigned CYCLE_BUDGET = 0,
    parameter int unsigned CYC_W        = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             stop_i,
    input  logic             StallF,
    input  logic             StallD,
    input  logic [31:0]      PCPlus4F,
    input  logic [31:0]      InstrD,
    output logic             core_reset,
    output logic             core_en,
    output logic [2:0]       state_o,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic [1:0]       fault_o,
    output logic             done_o
);

    localparam int unsigned PH_MAX = (RESET_CYC > DRAIN_CYC) ? RESET_CYC : DRAIN_CYC;
    localparam int          PH_W   = $clog2(PH_MAX + 1);

    state_e          state;
    state_e          nextState;
    fault_e          faultCode;
    logic [PH_W-1:0] phaseCnt;
    logic            primeEntry;
    logic            haltSeen;
    logic            pcBad;
    logic            budgetHit;
    logic            deadlock;

    assign core_reset = (state == IDLE) || (state == PRIME);
    assign core_en    = (state == RUN) || (state == STEP) || (state == DRAIN);
    assign state_o    = state;

    assign haltSeen   = core_en && !StallD && (InstrD == HALT_INSTR);
    assign pcBad      = core_en && (PCPlus4F > PC_LIMIT);
    assign budgetHit  = (CYCLE_BUDGET != 0) && core_en
                        && (cycle_cnt == CYC_W'(CYCLE_BUDGET - 1));
    assign primeEntry = (nextState == PRIME) && (state != PRIME);

    stall_watchdog #(.MAX_STALL(MAX_STALL)) uWatchdog (
        .CLK      (CLK),
        .reset    (reset),
        .clear    (primeEntry),
        .enable   (core_en),
        .StallF   (StallF),
        .StallD   (StallD),
        .deadlock (deadlock)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        faultCode = FAULT_NONE;
        if (deadlock)       faultCode = FAULT_DEADLOCK;
        else if (pcBad)     faultCode = FAULT_PC;
        else if (budgetHit) faultCode = FAULT_BUDGET;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (start_i) nextState = PRIME;
            PRIME: if (phaseCnt == PH_W'(RESET_CYC - 1)) nextState = RUN;
            RUN: begin
                if (faultCode != FAULT_NONE) nextState = FAULT;
                else if (haltSeen)           nextState = DRAIN;
                else if (stop_i)             nextState = PAUSE;
            end
            PAUSE: begin
                if (start_i)     nextState = RUN;
                else if (step_i) nextState = STEP;
            end
            STEP: begin
                if (faultCode != FAULT_NONE) nextState = FAULT;
                else if (haltSeen)           nextState = DRAIN;
                else                         nextState = PAUSE;
            end
            DRAIN: begin
                if (faultCode != FAULT_NONE)                  nextState = FAULT;
                else if (phaseCnt == PH_W'(DRAIN_CYC - 1))    nextState = HALT;
            end
            HALT, FAULT: if (start_i) nextState = PRIME;
        endcase
    end

    // phaseCnt times the PRIME and DRAIN dwell and restarts on every state change
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            phaseCnt <= '0;
            done_o   <= 1'b0;
        end else begin
            state  <= nextState;
            done_o <= (nextState == HALT) && (state != HALT);
            if (nextState != state)
                phaseCnt <= '0;
            else if ((state == PRIME) || (state == DRAIN))
                phaseCnt <= phaseCnt + PH_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            fault_o   <= FAULT_NONE;
        end else begin
            if (primeEntry)
                cycle_cnt <= '0;
            else if (core_en && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + CYC_W'(1);

            if (primeEntry)
                fault_o <= FAULT_NONE;
            else if ((nextState == FAULT) && (state != FAULT))
                fault_o <= faultCode;
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: a cycle model built from the
// behavioural rules, a per-cycle comparer, and directed scenarios with literal pins.
module tb_pipeline_run_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int          RESET_CYC = 2;
    localparam int          DRAIN_CYC = 3;
    localparam int          MAX_STALL = 10;
    localparam logic [31:0] PC_LIMIT  = 32'h00000070;
    localparam int          BUDGET    = 50;
    localparam longint      CNT_MAX   = 64'h00000000FFFFFFFF;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start_i, step_i, stop_i, StallF, StallD;
    logic [31:0] PCPlus4F, InstrD;
    logic        core_reset, core_en, done_o;
    logic [2:0]  state_o;
    logic [31:0] cycle_cnt;
    logic [1:0]  fault_o;

    int nErr   = 0;
    int nCheck = 0;
    int enCount = 0;
    int doneCount = 0;

    pipeline_run_ctrl #(
        .RESET_CYC(RESET_CYC), .DRAIN_CYC(DRAIN_CYC), .MAX_STALL(MAX_STALL),
        .PC_LIMIT(PC_LIMIT), .CYCLE_BUDGET(BUDGET), .CYC_W(32)
    ) dut (
        .CLK(CLK), .reset(reset), .start_i(start_i), .step_i(step_i), .stop_i(stop_i),
        .StallF(StallF), .StallD(StallD), .PCPlus4F(PCPlus4F), .InstrD(InstrD),
        .core_reset(core_reset), .core_en(core_en), .state_o(state_o),
        .cycle_cnt(cycle_cnt), .fault_o(fault_o), .done_o(done_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCheck++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: countdown timers and plain integers
    state_e mState;
    int     mLeft, mStall, mFault;
    longint mCycle;
    bit     mDone;

    always @(posedge CLK or posedge reset) begin : model
        bit     en, halt;
        int     stallNext, code;
        state_e nxt;
        if (reset) begin
            mState = IDLE; mLeft = 0; mStall = 0; mFault = 0; mCycle = 0; mDone = 0;
        end else begin
            en = (mState == RUN) || (mState == STEP) || (mState == DRAIN);
            stallNext = (en && StallF && StallD) ? mStall + 1 : 0;
            code = 0;
            if (en) begin
                if (stallNext > MAX_STALL)                   code = 1;
                else if (PCPlus4F > PC_LIMIT)                code = 2;
                else if (BUDGET != 0 && mCycle + 1 == BUDGET) code = 3;
            end
            halt = en && !StallD && (InstrD == 32'h0000000C);
            mDone = 0;
            nxt = mState;
            case (mState)
                IDLE:  if (start_i) nxt = PRIME;
                PRIME: begin mLeft--; if (mLeft == 0) nxt = RUN; end
                RUN:   if (code != 0) nxt = FAULT; else if (halt) nxt = DRAIN; else if (stop_i) nxt = PAUSE;
                PAUSE: if (start_i) nxt = RUN; else if (step_i) nxt = STEP;
                STEP:  if (code != 0) nxt = FAULT; else if (halt) nxt = DRAIN; else nxt = PAUSE;
                DRAIN: begin mLeft--; if (code != 0) nxt = FAULT; else if (mLeft == 0) nxt = HALT; end
                default: if (start_i) nxt = PRIME;
            endcase
            if (en && mCycle < CNT_MAX) mCycle++;
            mStall = stallNext;
            if (nxt == PRIME && mState != PRIME) begin
                mLeft = RESET_CYC; mCycle = 0; mFault = 0; mStall = 0;
            end
            if (nxt == DRAIN && mState != DRAIN) mLeft = DRAIN_CYC;
            if (nxt == FAULT && mState != FAULT) mFault = code;
            if (nxt == HALT && mState != HALT)   mDone = 1;
            mState = nxt;
        end
    end

    always @(negedge CLK) begin
        check("state", state_o, mState);
        check("core_reset", core_reset, (mState == IDLE) || (mState == PRIME));
        check("core_en", core_en, (mState == RUN) || (mState == STEP) || (mState == DRAIN));
        check("cycle_cnt", cycle_cnt, mCycle);
        check("fault", fault_o, mFault);
        check("done", done_o, mDone);
        if (core_en) enCount++;
        if (done_o)  doneCount++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulseStart();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    int base;

    initial begin
        reset = 1'b1; start_i = 0; step_i = 0; stop_i = 0; StallF = 0; StallD = 0;
        PCPlus4F = 32'h10; InstrD = 32'h0;
        #2;
        check("rst_state", state_o, 3'd0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_core_en", core_en, 1'b0);
        check("rst_fault", fault_o, 2'd0);
        check("rst_done", done_o, 1'b0);
        check("rst_cnt", cycle_cnt, 32'd0);
        tick(2);
        reset = 1'b0;

        // Start: PRIME holds core_reset for two cycles, then RUN
        tick(1);
        pulseStart();
        check("prime_state", state_o, 3'd1);
        check("prime_core_reset", core_reset, 1'b1);
        tick(1);
        check("prime2_core_reset", core_reset, 1'b1);
        tick(1);
        check("run_state", state_o, 3'd2);
        check("run_core_en", core_en, 1'b1);
        check("run_core_reset", core_reset, 1'b0);

        // Halt: syscall seen with cycle_cnt at 20, then a three-cycle drain
        tick(20);
        check("pre_halt_cnt", cycle_cnt, 32'd20);
        InstrD = HALT_INSTR;
        base = doneCount;
        tick(1);
        InstrD = 32'h0;
        check("drain_state", state_o, 3'd5);
        tick(3);
        check("halt_state", state_o, 3'd6);
        check("halt_cnt", cycle_cnt, 32'd24);
        check("halt_done", done_o, 1'b1);
        check("halt_fault", fault_o, 2'd0);
        tick(3);
        check("halt_done_once", doneCount - base, 1);
        check("halt_en_low", core_en, 1'b0);

        // Deadlock: the 11th consecutive full stall faults
        pulseStart();
        tick(2);
        StallF = 1; StallD = 1;
        tick(10);
        check("stall10_state", state_o, 3'd2);
        tick(1);
        check("deadlock_state", state_o, 3'd7);
        check("deadlock_fault", fault_o, 2'd1);
        check("deadlock_en", core_en, 1'b0);
        StallF = 0; StallD = 0;
        tick(2);

        // Ten stalls twice with a release in between: no fault
        pulseStart();
        tick(2);
        check("reprime_fault_clr", fault_o, 2'd0);
        StallF = 1; StallD = 1; tick(10);
        StallF = 0; StallD = 0; tick(1);
        StallF = 1; StallD = 1; tick(10);
        StallF = 0; StallD = 0; tick(2);
        check("stall_ok_state", state_o, 3'd2);
        check("stall_ok_fault", fault_o, 2'd0);

        // PC bound: equality legal, one word beyond faults
        PCPlus4F = 32'h70; tick(2);
        check("pc_eq_state", state_o, 3'd2);
        PCPlus4F = 32'h74; tick(1);
        check("pc_fault_state", state_o, 3'd7);
        check("pc_fault_code", fault_o, 2'd2);
        PCPlus4F = 32'h10;
        tick(1);

        // Pause and single-step; stalled syscall is not a halt
        pulseStart();
        tick(2);
        InstrD = HALT_INSTR; StallD = 1; tick(1);
        check("stalled_halt_ignored", state_o, 3'd2);
        InstrD = 32'h0; StallD = 0;
        step_i = 1; tick(2); step_i = 0;
        check("step_in_run_ignored", state_o, 3'd2);
        stop_i = 1; tick(1); stop_i = 0;
        check("pause_state", state_o, 3'd3);
        check("pause_cnt", cycle_cnt, 32'd4);
        check("pause_core_reset", core_reset, 1'b0);
        stop_i = 1; tick(2); stop_i = 0;
        base = enCount;
        for (int i = 0; i < 3; i++) begin
            step_i = 1; tick(1); step_i = 0;
            check("step_en", core_en, 1'b1);
            tick(2);
        end
        check("step_en_cycles", enCount - base, 3);
        check("step_cnt", cycle_cnt, 32'd7);
        start_i = 1; step_i = 1; tick(1); start_i = 0; step_i = 0;
        check("resume_state", state_o, 3'd2);
        check("resume_core_reset", core_reset, 1'b0);

        // Budget: fault after 50 enabled cycles
        tick(42);
        check("budget49_state", state_o, 3'd2);
        tick(1);
        check("budget_state", state_o, 3'd7);
        check("budget_fault", fault_o, 2'd3);
        check("budget_cnt", cycle_cnt, 32'd50);
        tick(3);
        check("fault_frozen_cnt", cycle_cnt, 32'd50);

        // Asynchronous reset mid-FAULT, then a fresh start
        reset = 1'b1;
        #1;
        check("async_state", state_o, 3'd0);
        check("async_core_reset", core_reset, 1'b1);
        check("async_fault", fault_o, 2'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        pulseStart();
        check("restart_state", state_o, 3'd1);
        check("restart_cnt", cycle_cnt, 32'd0);
        tick(4);
        check("restart_run", state_o, 3'd2);

        $display("Result: errors=%0d of %0d checks", nErr, nCheck);
        $finish;
    end

endmodule
